// File: rtl/csr_regfile.sv
// Machine-mode CSR register file for the RV32IM core: M-mode state, 64-bit counters,
// trap/mret sequencing and interrupt-pending generation.
module csr_regfile #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h8000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_rd_i,
  input  logic        csr_wr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_idx_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        stall_i,
  input  logic        retire_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Architectural state; interrupt enable/pending vectors are {ext, timer, sw}
  logic            mstatus_mie_q,  mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]      mie_q,          mie_d;
  logic [2:0]      mip_q,          mip_d;
  logic [XLEN-1:0] mtvec_q,        mtvec_d;
  logic [XLEN-1:0] mscratch_q,     mscratch_d;
  logic [XLEN-1:0] mepc_q,         mepc_d;
  logic [XLEN-1:0] mcause_q,       mcause_d;
  logic [XLEN-1:0] mtval_q,        mtval_d;
  logic [CW-1:0]   mcycle_q,       mcycle_d;
  logic [CW-1:0]   minstret_q,     minstret_d;

  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] mie_rd;
  logic [XLEN-1:0] mip_rd;
  logic [XLEN-1:0] mtvec_base;
  logic            illegal;
  logic            wr_en;
  logic            cyc_wr;
  logic            ins_wr;
  logic            ins_inc;
  logic            unused_rd;

  // Read request is informational only: reads are side-effect free
  assign unused_rd = csr_rd_i;

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
  assign mie_rd     = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
  assign mip_rd     = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};

  // Combinational read mux; unsupported addresses read zero
  always_comb begin
    rdata = '0;
    case (csr_idx_i)
      ADDR_MSTATUS:   rdata = mstatus_rd;
      ADDR_MISA:      rdata = MISA_VALUE;
      ADDR_MIE:       rdata = mie_rd;
      ADDR_MTVEC:     rdata = mtvec_q;
      ADDR_MSCRATCH:  rdata = mscratch_q;
      ADDR_MEPC:      rdata = mepc_q;
      ADDR_MCAUSE:    rdata = mcause_q;
      ADDR_MTVAL:     rdata = mtval_q;
      ADDR_MIP:       rdata = mip_rd;
      ADDR_MCYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH: rdata = minstret_q[63:32];
      ADDR_MVENDORID: rdata = '0;
      ADDR_MARCHID:   rdata = '0;
      ADDR_MIMPID:    rdata = '0;
      ADDR_MHARTID:   rdata = HART_ID;
      default:        rdata = '0;
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign illegal       = csr_wr_i & (csr_idx_i[11:10] == 2'b11);
  assign csr_illegal_o = illegal;
  assign wr_en         = csr_wr_i & (csr_op_i != OP_NONE) & ~stall_i & ~illegal & ~trap_valid_i;

  // Read-modify-write operand from the old value
  always_comb begin
    wval = csr_wdata_i;
    case (csr_op_i)
      OP_RW:   wval = csr_wdata_i;
      OP_RS:   wval = rdata | csr_wdata_i;
      OP_RC:   wval = rdata & ~csr_wdata_i;
      default: wval = csr_wdata_i;
    endcase
  end

  assign cyc_wr  = wr_en & ((csr_idx_i == ADDR_MCYCLE) | (csr_idx_i == ADDR_MCYCLEH));
  assign ins_wr  = wr_en & ((csr_idx_i == ADDR_MINSTRET) | (csr_idx_i == ADDR_MINSTRETH));
  assign ins_inc = retire_i & ~stall_i & ~trap_valid_i & ~ins_wr;

  // Next-state: counters, then software writes, then trap/mret sequencing
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mip_d          = {irq_ext_i, irq_timer_i, irq_sw_i};
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = cyc_wr  ? mcycle_q   : mcycle_q + CW'(1);
    minstret_d     = ins_inc ? minstret_q + CW'(1) : minstret_q;

    if (wr_en) begin
      case (csr_idx_i)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        ADDR_MIE:       mie_d                = {wval[11], wval[7], wval[3]};
        ADDR_MTVEC:     mtvec_d              = wval & ~XLEN'(32'h2);
        ADDR_MSCRATCH:  mscratch_d           = wval;
        ADDR_MEPC:      mepc_d               = wval & ~XLEN'(32'h3);
        ADDR_MCAUSE:    mcause_d             = wval;
        ADDR_MTVAL:     mtval_d              = wval;
        ADDR_MCYCLE:    mcycle_d[31:0]       = wval;
        ADDR_MCYCLEH:   mcycle_d[63:32]      = wval;
        ADDR_MINSTRET:  minstret_d[31:0]     = wval;
        ADDR_MINSTRETH: minstret_d[63:32]    = wval;
        default:        ;
      endcase
    end

    // mret overrides a coincident mstatus write
    if (trap_valid_i) begin
      mepc_d         = trap_pc_i & ~XLEN'(32'h3);
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Vectored mode offsets only asynchronous interrupts
  assign mtvec_base    = {mtvec_q[31:2], 2'b00};
  assign trap_vector_o = (mtvec_q[0] & trap_cause_i[31])
                         ? mtvec_base + {25'd0, trap_cause_i[4:0], 2'b00}
                         : mtvec_base;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = mstatus_mie_q & |(mie_q & mip_q);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile: reset values, RMW ops, traps/mret,
// illegal/ignored writes, counter carry and write suppression, interrupt pending.
module tb_csr_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        csr_rd_i, csr_wr_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_idx_i;
  logic [31:0] csr_wdata_i, csr_rdata_o;
  logic        csr_illegal_o;
  logic        stall_i, retire_i, trap_valid_i, mret_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic [31:0] trap_vector_o, mepc_o;
  logic        irq_pending_o;

  int n_vec = 0;
  int n_err = 0;

  csr_regfile dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_rd_i(csr_rd_i), .csr_wr_i(csr_wr_i),
    .csr_op_i(csr_op_i), .csr_idx_i(csr_idx_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o), .stall_i(stall_i),
    .retire_i(retire_i), .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
    .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
    .trap_vector_o(trap_vector_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] idx, input logic [31:0] exp, input string tag);
    csr_idx_i = idx;
    #1;
    chk(tag, csr_rdata_o, exp);
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] d);
    csr_wr_i    = 1'b1;
    csr_rd_i    = 1'b1;
    csr_op_i    = op;
    csr_idx_i   = idx;
    csr_wdata_i = d;
  endtask

  task automatic idle();
    csr_wr_i = 1'b0;
    csr_rd_i = 1'b0;
    csr_op_i = 2'b00;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] d);
    drive(op, idx, d);
    tick();
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    csr_idx_i = '0; csr_wdata_i = '0;
    stall_i = 0; retire_i = 0; trap_valid_i = 0; mret_i = 0;
    trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
    irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset state
    rd(12'h305, 32'h8000_0000, "rst_mtvec");
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'hF14, 32'h0000_0000, "rst_mhartid");
    rd(12'hB00, 32'h0000_0000, "rst_mcycle");
    chk("rst_mepc_o", mepc_o, 32'h0);
    chk("rst_irq_pending", {31'd0, irq_pending_o}, 32'h0);
    repeat (5) tick();
    rd(12'hB00, 32'd5, "mcycle_after5");
    rd(12'h301, 32'h4000_1100, "misa");

    // mscratch RW/RS/RC with old-value readback
    drive(2'b01, 12'h340, 32'hDEAD_BEEF); #1 chk("rw_old", csr_rdata_o, 32'h0); tick();
    drive(2'b10, 12'h340, 32'h0000_0010); #1 chk("rs_old", csr_rdata_o, 32'hDEAD_BEEF); tick();
    drive(2'b11, 12'h340, 32'hDEAD_0000); #1 chk("rc_old", csr_rdata_o, 32'hDEAD_BEFF); tick();
    idle();
    rd(12'h340, 32'h0000_BEFF, "mscratch_final");

    // mstatus MIE set, mtvec WARL, mepc WARL
    wr(2'b10, 12'h300, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_mie");
    wr(2'b01, 12'h305, 32'h8000_0103);
    rd(12'h305, 32'h8000_0101, "mtvec_warl");
    wr(2'b01, 12'h341, 32'h0000_2003);
    rd(12'h341, 32'h0000_2000, "mepc_warl");

    // Trap vector selection
    trap_cause_i = 32'h8000_0007; #1 chk("vec_irq7", trap_vector_o, 32'h8000_011C);
    trap_cause_i = 32'h0000_0002; #1 chk("vec_exc2", trap_vector_o, 32'h8000_0100);

    // Trap with a coincident write that must be dropped
    trap_pc_i = 32'h0000_1237; trap_tval_i = 32'h0000_0ABC; trap_valid_i = 1'b1;
    drive(2'b01, 12'h340, 32'h5555_5555);
    tick();
    trap_valid_i = 1'b0; idle();
    chk("trap_mepc_o", mepc_o, 32'h0000_1234);
    rd(12'h342, 32'h0000_0002, "trap_mcause");
    rd(12'h343, 32'h0000_0ABC, "trap_mtval");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    rd(12'h340, 32'h0000_BEFF, "trap_drop_wr");

    // mret restores MIE; coincident mstatus write loses
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    rd(12'h300, 32'h0000_1888, "mret_mstatus");
    mret_i = 1'b1; drive(2'b11, 12'h300, 32'h0000_0088); tick(); mret_i = 1'b0; idle();
    rd(12'h300, 32'h0000_1888, "mret_wins");

    // Read-only and ignored writes
    drive(2'b01, 12'hF14, 32'h0000_1234); #1 chk("illegal_f14", {31'd0, csr_illegal_o}, 32'h1);
    tick(); idle();
    rd(12'hF14, 32'h0000_0000, "mhartid_kept");
    drive(2'b01, 12'h344, 32'hFFFF_FFFF); #1 chk("mip_not_illegal", {31'd0, csr_illegal_o}, 32'h0);
    tick(); idle();
    rd(12'h344, 32'h0000_0000, "mip_ignored");

    // Stall blocks writes
    stall_i = 1'b1; wr(2'b01, 12'h340, 32'h0000_0001); stall_i = 1'b0;
    rd(12'h340, 32'h0000_BEFF, "stall_blocks_wr");

    // Counter carry across halves
    wr(2'b01, 12'hB80, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
    rd(12'hB80, 32'h0000_0000, "mcycleh_held");
    tick();
    rd(12'hB00, 32'h0000_0000, "mcycle_wrap");
    rd(12'hB80, 32'h0000_0001, "mcycleh_carry");

    // minstret write suppresses the retire increment
    retire_i = 1'b1; wr(2'b01, 12'hB02, 32'h0000_0100); retire_i = 1'b0;
    rd(12'hB02, 32'h0000_0100, "minstret_written");
    retire_i = 1'b1; tick(); retire_i = 1'b0;
    rd(12'hB02, 32'h0000_0101, "minstret_inc");
    retire_i = 1'b1; stall_i = 1'b1; tick(); retire_i = 1'b0; stall_i = 1'b0;
    rd(12'hB02, 32'h0000_0101, "minstret_stall");
    rd(12'hB82, 32'h0000_0000, "minstreth");

    // Interrupt enable masking and one-cycle pending latency
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_mask");
    wr(2'b01, 12'h304, 32'h0000_0800);
    irq_timer_i = 1'b1; tick();
    chk("irq_masked", {31'd0, irq_pending_o}, 32'h0);
    irq_timer_i = 1'b0;
    irq_ext_i = 1'b1; #1;
    chk("irq_not_yet", {31'd0, irq_pending_o}, 32'h0);
    tick();
    chk("irq_pending", {31'd0, irq_pending_o}, 32'h1);
    rd(12'h344, 32'h0000_0800, "mip_ext");
    irq_ext_i = 1'b0; tick();
    chk("irq_clear", {31'd0, irq_pending_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
